regfile_dump_reader: RTL and testbench

Read-side controller for the 32 x 32-bit register file. On a Start pulse it walks the register addresses from FIRST_ADDR to LAST_ADDR. For each address it issues a registered read and captures the 32-bit word. It then presents the word on the 8-bit LED bus one byte at a time, least-significant byte first, holding each byte for HOLD_CYCLES clocks. It sits between the register file's read port and the board LEDs, and replaces manual Addr/choose switching.

---
 rtl/regfile_dump_reader_if.sv | 22 ++
 rtl/regfile_dump_reader.sv | 119 +++++++++++
 tb/tb_regfile_dump_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Bus between the dump reader, the register file read port and the LED driver.
// master is the dump reader side; slave is the register file / board side.
interface regfile_dump_reader_if;
    logic        Start;
    logic [31:0] Rd_Data;
    logic [4:0]  Addr;
    logic        Read_Reg;
    logic [1:0]  choose;
    logic [7:0]  LED;
    logic        Busy;
    logic        Done;

    modport master (
        input  Start, Rd_Data,
        output Addr, Read_Reg, choose, LED, Busy, Done
    );

    modport slave (
        output Start, Rd_Data,
        input  Addr, Read_Reg, choose, LED, Busy, Done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register addresses FIRST_ADDR..LAST_ADDR, reads each word once and shows
// it on the LED bus byte by byte (LSB first), HOLD_CYCLES clocks per byte.
module regfile_dump_reader #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [4:0] FIRST_ADDR  = 5'd0,
    parameter logic [4:0] LAST_ADDR   = 5'd31
) (
    input logic                   Clk,
    input logic                   Reset,
    regfile_dump_reader_if.master bus
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, SHOW, NEXT, FIN} state_t;

    state_t           state_q, state_nxt;
    logic [4:0]       addr_q, addr_nxt;
    logic             read_reg_q, read_reg_nxt;
    logic [1:0]       choose_q, choose_nxt;
    logic [7:0]       led_q, led_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [31:0]      data_q, data_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       choose_inc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= FIRST_ADDR;
            read_reg_q <= 1'b0;
            choose_q   <= 2'd0;
            led_q      <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= 32'h0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            addr_q     <= addr_nxt;
            read_reg_q <= read_reg_nxt;
            choose_q   <= choose_nxt;
            led_q      <= led_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            data_q     <= data_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

    // Outputs are registered: strobes are set on the edge that enters their state.
    always_comb begin
        state_nxt    = state_q;
        addr_nxt     = addr_q;
        read_reg_nxt = 1'b0;
        choose_nxt   = choose_q;
        led_nxt      = led_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        data_nxt     = data_q;
        cnt_nxt      = cnt_q;
        choose_inc   = choose_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt    = REQ;
                    addr_nxt     = FIRST_ADDR;
                    busy_nxt     = 1'b1;
                    read_reg_nxt = 1'b1;
                end
            end
            REQ: state_nxt = CAPT;
            CAPT: begin
                data_nxt   = bus.Rd_Data;
                led_nxt    = bus.Rd_Data[7:0];
                choose_nxt = 2'd0;
                cnt_nxt    = '0;
                state_nxt  = SHOW;
            end
            SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    if (choose_q != 2'd3) begin
                        choose_nxt = choose_inc;
                        cnt_nxt    = '0;
                        led_nxt    = data_q[{choose_inc, 3'b000} +: 8];
                    end else begin
                        state_nxt = NEXT;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt     = addr_q + 5'd1;
                    read_reg_nxt = 1'b1;
                    state_nxt    = REQ;
                end
            end
            FIN: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Addr     = addr_q;
    assign bus.Read_Reg = read_reg_q;
    assign bus.choose   = choose_q;
    assign bus.LED      = led_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Three dump readers with different parameters, a registered register-file model
// that drives garbage on Rd_Data outside the valid cycle, and a cycle-offset model.
module tb_regfile_dump_reader;
    localparam int NI = 3;
    localparam int HOLD_P  [NI] = '{2, 1, 3};
    localparam int FIRST_P [NI] = '{5, 0, 7};
    localparam int LAST_P  [NI] = '{5, 31, 10};

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [NI-1:0] start = '0;
    logic [31:0]   mem [NI][32];
    logic [4:0]    o_addr   [NI];
    logic          o_rr     [NI];
    logic [1:0]    o_choose [NI];
    logic [7:0]    o_led    [NI];
    logic          o_busy   [NI];
    logic          o_done   [NI];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        regfile_dump_reader_if bus ();
        logic [31:0] rd = 32'h0;

        always @(posedge Clk) begin
            if (bus.Read_Reg) rd <= mem[g][bus.Addr];
            else rd <= ($urandom_range(0, 1) != 0) ? 32'hDEADBEEF : $urandom;
        end

        assign bus.Start   = start[g];
        assign bus.Rd_Data = rd;
        assign o_addr[g]   = bus.Addr;
        assign o_rr[g]     = bus.Read_Reg;
        assign o_choose[g] = bus.choose;
        assign o_led[g]    = bus.LED;
        assign o_busy[g]   = bus.Busy;
        assign o_done[g]   = bus.Done;

        regfile_dump_reader #(
            .HOLD_CYCLES(HOLD_P[g]),
            .FIRST_ADDR (5'(FIRST_P[g])),
            .LAST_ADDR  (5'(LAST_P[g]))
        ) u_dut (
            .Clk  (Clk),
            .Reset(Reset),
            .bus  (bus.master)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk($sformatf("%s i%0d addr", tag, i), 32'(o_addr[i]), 32'(FIRST_P[i]));
        chk($sformatf("%s i%0d read_reg", tag, i), 32'(o_rr[i]), 0);
        chk($sformatf("%s i%0d choose", tag, i), 32'(o_choose[i]), 0);
        chk($sformatf("%s i%0d led", tag, i), 32'(o_led[i]), 0);
        chk($sformatf("%s i%0d busy", tag, i), 32'(o_busy[i]), 0);
        chk($sformatf("%s i%0d done", tag, i), 32'(o_done[i]), 0);
    endtask

    // Expected trace is a function of the cycle offset t from the first read:
    // each register takes P = 3 + 4*H cycles (read, capture, 4*H show, advance),
    // followed by one Done cycle.
    task automatic run_dump(input int i, input int extra_start_t);
        int h = HOLD_P[i];
        int n = LAST_P[i] - FIRST_P[i] + 1;
        int p_len = 3 + 4 * h;
        int reads = 0;
        int dones = 0;
        logic [31:0] w;
        logic [31:0] last_w = mem[i][LAST_P[i]];
        @(negedge Clk) start[i] = 1'b1;
        @(negedge Clk) start[i] = 1'b0;
        for (int t = 0; t <= n * p_len; t++) begin
            int r, p, k, e_addr;
            bit show, e_rr, e_done;
            start[i] = (t == extra_start_t);
            if (t == n * p_len) begin
                e_addr = LAST_P[i]; e_rr = 0; e_done = 1; show = 1; k = 3; w = last_w;
            end else begin
                r = t / p_len; p = t % p_len;
                e_addr = FIRST_P[i] + r; e_rr = (p == 0); e_done = 0;
                show = (p >= 2); w = mem[i][e_addr];
                k = (p >= 2 + 4 * h) ? 3 : (p - 2) / h;
            end
            chk($sformatf("i%0d t%0d addr", i, t), 32'(o_addr[i]), 32'(e_addr));
            chk($sformatf("i%0d t%0d read_reg", i, t), 32'(o_rr[i]), 32'(e_rr));
            chk($sformatf("i%0d t%0d done", i, t), 32'(o_done[i]), 32'(e_done));
            chk($sformatf("i%0d t%0d busy", i, t), 32'(o_busy[i]), 1);
            if (show) begin
                chk($sformatf("i%0d t%0d choose", i, t), 32'(o_choose[i]), 32'(k));
                chk($sformatf("i%0d t%0d led", i, t), 32'(o_led[i]), 32'(w[8*k +: 8]));
            end
            reads += int'(o_rr[i]);
            dones += int'(o_done[i]);
            @(negedge Clk);
        end
        start[i] = 1'b0;
        chk($sformatf("i%0d read count", i), 32'(reads), 32'(n));
        chk($sformatf("i%0d done count", i), 32'(dones), 1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("i%0d idle%0d busy", i, c), 32'(o_busy[i]), 0);
            chk($sformatf("i%0d idle%0d done", i, c), 32'(o_done[i]), 0);
            chk($sformatf("i%0d idle%0d read_reg", i, c), 32'(o_rr[i]), 0);
            chk($sformatf("i%0d idle%0d addr", i, c), 32'(o_addr[i]), 32'(LAST_P[i]));
            chk($sformatf("i%0d idle%0d led", i, c), 32'(o_led[i]), 32'(last_w[31:24]));
            @(negedge Clk);
        end
    endtask

    initial begin
        int dones;
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 32; a++) mem[i][a] = $urandom;
        mem[0][5] = 32'h44332211;
        for (int a = 0; a < 32; a++) mem[1][a] = {4{3'b000, 5'(a)}};

        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < NI; i++) chk_reset(i, "reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Single register; a Start during the Done cycle must be ignored.
        run_dump(0, 1 * (3 + 4 * HOLD_P[0]));
        // Full sweep; a Start during SHOW of address 3 must be ignored.
        run_dump(1, 3 * (3 + 4 * HOLD_P[1]) + 2);
        run_dump(2, int'($urandom_range(1, 4 * (3 + 4 * HOLD_P[2]) - 1)));

        // Abort during SHOW of address 1 with choose = 2.
        @(negedge Clk) start[1] = 1'b1;
        @(negedge Clk) start[1] = 1'b0;
        repeat ((3 + 4 * HOLD_P[1]) + 2 + 2 * HOLD_P[1]) @(negedge Clk);
        chk("abort pre choose", 32'(o_choose[1]), 2);
        chk("abort pre addr", 32'(o_addr[1]), 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk_reset(1, "abort");
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            dones += int'(o_done[1]);
            if (o_busy[1]) dones += 100;
            @(negedge Clk);
        end
        chk("abort no done/busy", 32'(dones), 0);
        run_dump(1, -1);

        // Reset and Start in the same cycle: reset wins, nothing is remembered.
        @(negedge Clk);
        Reset = 1'b1; start[2] = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; start[2] = 1'b0;
        chk("rst+start busy", 32'(o_busy[2]), 0);
        chk("rst+start read_reg", 32'(o_rr[2]), 0);
        @(negedge Clk);
        chk("rst+start later busy", 32'(o_busy[2]), 0);
        chk("rst+start later read_reg", 32'(o_rr[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
